// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - two-master round-robin bus arbiter with turnaround and grant timeout
module bus_arbiter #(
    parameter int TIMEOUT = 8,
    parameter int CNT_W   = 8
) (
    input  logic CLK,
    input  logic RSTN,
    input  logic B_REQ1,
    input  logic B_REQ2,
    input  logic B_UTIL,
    output logic B_GRANT1,
    output logic B_GRANT2,
    output logic B_BUSY,
    output logic B_OWNER,
    output logic B_TOUT
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_GRANT   = 2'd1,
        S_RELEASE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_grant1, r_grant2, r_busy, r_owner, r_tout;
    logic               w_grant1_nxt, w_grant2_nxt, w_owner_nxt, w_tout_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic               r_used, w_used_nxt;
    logic               r_blk1, r_blk2, w_blk1_nxt, w_blk2_nxt;

    logic               w_elig1, w_elig2, w_pick2, w_req_own, w_used_now;

    assign w_elig1    = B_REQ1 & ~r_blk1;
    assign w_elig2    = B_REQ2 & ~r_blk2;
    // On a tie the master that did not own the bus last wins.
    assign w_pick2    = (w_elig1 & w_elig2) ? ~r_owner : w_elig2;
    assign w_req_own  = r_owner ? B_REQ2 : B_REQ1;
    assign w_used_now = r_used | B_UTIL;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_state  <= S_IDLE;
            r_grant1 <= 1'b0;
            r_grant2 <= 1'b0;
            r_busy   <= 1'b0;
            r_owner  <= 1'b1;
            r_tout   <= 1'b0;
            r_cnt    <= '0;
            r_used   <= 1'b0;
            r_blk1   <= 1'b0;
            r_blk2   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_grant1 <= w_grant1_nxt;
            r_grant2 <= w_grant2_nxt;
            r_busy   <= w_grant1_nxt | w_grant2_nxt;
            r_owner  <= w_owner_nxt;
            r_tout   <= w_tout_nxt;
            r_cnt    <= w_cnt_nxt;
            r_used   <= w_used_nxt;
            r_blk1   <= w_blk1_nxt;
            r_blk2   <= w_blk2_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_grant1_nxt = r_grant1;
        w_grant2_nxt = r_grant2;
        w_owner_nxt  = r_owner;
        w_tout_nxt   = 1'b0;
        w_cnt_nxt    = r_cnt;
        w_used_nxt   = r_used;
        // A block is lifted by any cycle where that master's request is low.
        w_blk1_nxt   = r_blk1 & B_REQ1;
        w_blk2_nxt   = r_blk2 & B_REQ2;

        case (r_state)
            S_IDLE: begin
                w_grant1_nxt = 1'b0;
                w_grant2_nxt = 1'b0;
                if (w_elig1 | w_elig2) begin
                    w_state_nxt  = S_GRANT;
                    w_grant1_nxt = ~w_pick2;
                    w_grant2_nxt = w_pick2;
                    w_owner_nxt  = w_pick2;
                    w_cnt_nxt    = '0;
                    w_used_nxt   = 1'b0;
                end
            end
            S_GRANT: begin
                if (!w_req_own) begin
                    w_state_nxt  = S_RELEASE;
                    w_grant1_nxt = 1'b0;
                    w_grant2_nxt = 1'b0;
                end else if (!w_used_now && (r_cnt == CNT_W'(TIMEOUT - 1))) begin
                    // Unused grant: revoke and lock the owner out until it lets go of REQ.
                    w_state_nxt  = S_RELEASE;
                    w_grant1_nxt = 1'b0;
                    w_grant2_nxt = 1'b0;
                    w_tout_nxt   = 1'b1;
                    if (r_owner) begin
                        w_blk2_nxt = 1'b1;
                    end else begin
                        w_blk1_nxt = 1'b1;
                    end
                end else begin
                    w_used_nxt = w_used_now;
                    if (!w_used_now) begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
            end
            S_RELEASE: begin
                w_state_nxt  = S_IDLE;
                w_grant1_nxt = 1'b0;
                w_grant2_nxt = 1'b0;
            end
            default: begin
                w_state_nxt  = S_IDLE;
                w_grant1_nxt = 1'b0;
                w_grant2_nxt = 1'b0;
            end
        endcase
    end

    assign B_GRANT1 = r_grant1;
    assign B_GRANT2 = r_grant2;
    assign B_BUSY   = r_busy;
    assign B_OWNER  = r_owner;
    assign B_TOUT   = r_tout;

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - directed self-checking bench for bus_arbiter
module tb_bus_arbiter;

    logic CLK    = 1'b0;
    logic RSTN   = 1'b0;
    logic B_REQ1 = 1'b0;
    logic B_REQ2 = 1'b0;
    logic B_UTIL = 1'b0;
    logic B_GRANT1, B_GRANT2, B_BUSY, B_OWNER, B_TOUT;

    int total = 0;
    int bad   = 0;

    // {grant1, grant2, busy, owner, tout}
    localparam logic [4:0] G1  = 5'b10100;
    localparam logic [4:0] G2  = 5'b01110;
    localparam logic [4:0] L0  = 5'b00000;
    localparam logic [4:0] L1  = 5'b00010;
    localparam logic [4:0] TO2 = 5'b00011;

    bus_arbiter #(.TIMEOUT(8), .CNT_W(8)) dut (
        .CLK      (CLK),
        .RSTN     (RSTN),
        .B_REQ1   (B_REQ1),
        .B_REQ2   (B_REQ2),
        .B_UTIL   (B_UTIL),
        .B_GRANT1 (B_GRANT1),
        .B_GRANT2 (B_GRANT2),
        .B_BUSY   (B_BUSY),
        .B_OWNER  (B_OWNER),
        .B_TOUT   (B_TOUT)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #2;
    endtask

    task automatic chk(input string tag, input logic [4:0] exp);
        logic [4:0] obs;
        obs = {B_GRANT1, B_GRANT2, B_BUSY, B_OWNER, B_TOUT};
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset state
        step();
        step();
        chk("reset", L1);
        #3 RSTN = 1'b1;

        // Single master 1 tenure with a B_UTIL pulse
        step();
        B_REQ1 = 1'b1;
        step();
        chk("m1_grant", G1);
        B_UTIL = 1'b1;
        step();
        chk("m1_util", G1);
        B_UTIL = 1'b0;
        step();
        chk("m1_hold_a", G1);
        step();
        chk("m1_hold_b", G1);
        B_REQ1 = 1'b0;
        step();
        chk("m1_release", L0);
        step();
        chk("m1_idle", L0);

        // Reset between edges restores owner = 1 so master 1 wins the first tie
        #3 RSTN = 1'b0;
        #1 chk("reset_pulse", L1);
        RSTN = 1'b1;
        step();

        // Round-robin: M1, M2, M1, M2 with five grant cycles each
        B_REQ1 = 1'b1;
        B_REQ2 = 1'b1;
        B_UTIL = 1'b1;
        for (int t = 0; t < 4; t++) begin
            logic [4:0] eg, el;
            eg = (t % 2 == 0) ? G1 : G2;
            el = (t % 2 == 0) ? L0 : L1;
            step();
            chk($sformatf("rr%0d_grant", t), eg);
            for (int c = 0; c < 4; c++) begin
                step();
                chk($sformatf("rr%0d_hold%0d", t, c), eg);
            end
            if (t % 2 == 0) B_REQ1 = 1'b0; else B_REQ2 = 1'b0;
            if (t == 3) B_REQ1 = 1'b0;
            step();
            chk($sformatf("rr%0d_release", t), el);
            if (t != 3) begin
                if (t % 2 == 0) B_REQ1 = 1'b1; else B_REQ2 = 1'b1;
            end
            step();
            chk($sformatf("rr%0d_idle", t), el);
        end
        B_UTIL = 1'b0;

        // Timeout on master 2: eight grant cycles, one B_TOUT pulse, then blocked
        B_REQ2 = 1'b1;
        step();
        chk("to_grant", G2);
        for (int c = 1; c < 8; c++) begin
            step();
            chk($sformatf("to_hold%0d", c), G2);
        end
        step();
        chk("to_revoke", TO2);
        step();
        chk("to_idle", L1);
        step();
        chk("to_blocked_a", L1);
        step();
        chk("to_blocked_b", L1);

        // Blocked master 2 does not stop master 1 from getting the bus
        B_REQ1 = 1'b1;
        step();
        chk("blk_m1_grant", G1);
        B_UTIL = 1'b1;
        step();
        chk("blk_m1_util", G1);
        B_UTIL = 1'b0;
        B_REQ1 = 1'b0;
        step();
        chk("blk_m1_release", L0);
        step();
        chk("blk_m1_idle", L0);
        step();
        chk("blk_m2_still_blocked", L0);
        B_REQ2 = 1'b0;
        step();
        chk("blk_m2_drop", L0);
        B_REQ2 = 1'b1;
        step();
        chk("blk_m2_regrant", G2);
        B_REQ2 = 1'b0;
        step();
        chk("blk_m2_release", L1);
        step();
        chk("blk_m2_idle", L1);

        // REQ1 falls on the same edge the counter would time out
        B_REQ1 = 1'b1;
        step();
        chk("race_grant", G1);
        for (int c = 1; c < 8; c++) begin
            step();
            chk($sformatf("race_hold%0d", c), G1);
        end
        B_REQ1 = 1'b0;
        step();
        chk("race_release_no_tout", L0);
        B_REQ1 = 1'b1;
        step();
        chk("race_idle", L0);
        step();
        chk("race_not_blocked", G1);

        // Asynchronous reset mid-tenure with both requests pending
        B_REQ2 = 1'b1;
        step();
        chk("arst_before", G1);
        #3 RSTN = 1'b0;
        #1 chk("arst_immediate", L1);
        RSTN = 1'b1;
        step();
        chk("arst_regrant", G1);

        B_REQ1 = 1'b0;
        B_REQ2 = 1'b0;
        step();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
